rtlfuzz_dromajo: RTL and testbench
==================================

RTLFUZZ_DROMAJO -- requirements
Module: rtlfuzz_dromajo

Interface
REQ-001 SHALL have parameter PC_W, default 40: width of committed-instruction address.
REQ-002 SHALL have parameter HART_W, default 1: width of hartid.
REQ-003 SHALL have parameter TRACK_HART, default 0: only commits from this hart are monitored.
REQ-004 SHALL have parameter MAX_COMMITS, default 0: commit-count limit forcing finish; 0 disables the limit.
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 SHALL have port valid  input  1  one instruction retires this cycle.
REQ-008 SHALL have port hartid  input  HART_W  hart of the retiring instruction.
REQ-009 SHALL have port pc  input  PC_W  address of the retiring instruction.
REQ-010 SHALL have port inst  input  32  encoding of the retiring instruction.
REQ-011 SHALL have port wdata  input  64  register-file writeback value of the retiring instruction.
REQ-012 SHALL have port mstatus  output  64  last mstatus value read by a retired CSR instruction.
REQ-013 SHALL have port finish  output  1  test-end indication, sticky until reset.

Function
REQ-014 A commit SHALL be a rising clock edge with reset=1, valid=1 and hartid==TRACK_HART; all other edges are ignored.
REQ-015 SHALL keep a 64-bit commit counter, +1 per commit; saturates at all-ones, no wrap.
REQ-016 SHALL set finish on the edge of a commit whose inst==32'h0000006F (jal x0,0 self-loop); finish visible the following cycle (1-cycle latency).
REQ-017 SHALL set finish on the edge of a commit whose inst==32'h10500073 (wfi), same latency.
REQ-018 When MAX_COMMITS!=0, SHALL set finish on the edge where the commit counter becomes equal to MAX_COMMITS.
REQ-019 Once set, finish SHALL remain 1 regardless of further inputs until reset; later commits still update the counter and mstatus.
REQ-020 A commit SHALL be an mstatus read when inst[6:0]==7'h73, inst[14:12] in {1,2,3,5,6,7}, inst[31:20]==12'h300 and inst[11:7]!=0.
REQ-021 On an mstatus-read commit, mstatus SHALL load wdata, visible the following cycle.
REQ-022 Commits with rd==x0, other CSR addresses or non-CSR opcodes SHALL leave mstatus unchanged.
REQ-023 Finish triggers from REQ-016..018 in the same commit SHALL be ORed; they have no interaction with the mstatus update.
REQ-024 pc SHALL be latched per commit as last_pc (internal, debug only); it SHALL NOT affect outputs.
REQ-025 Inputs SHALL be used only on commit edges; X on inputs while valid=0 SHALL NOT propagate to state.

Reset
REQ-026 While reset=0, SHALL asynchronously force finish=0, mstatus=0, commit counter=0, last_pc=0.
REQ-027 Deassertion of reset SHALL take effect at the next rising clock edge; a commit on that same edge is processed normally.
REQ-028 Asserting reset mid-run (including after finish) SHALL clear all state immediately, without waiting for a clock edge.

Verification
REQ-029 Reset low, then high; 5 commits of inst=32'h00000013 -> finish=0, mstatus=0 throughout.
REQ-030 Commit inst=32'h0000006F at pc=40'h80000100 -> finish=1 the next cycle; finish stays 1 through 10 more random commits.
REQ-031 Commit inst=32'h300022F3 (csrr t0,mstatus), wdata=64'h0000000A00001800 -> mstatus=64'h0000000A00001800 next cycle; then csrr x0,mstatus with other wdata -> mstatus unchanged.
REQ-032 MAX_COMMITS=3: commits at cycles 1, 2, 4 with valid=0 at cycle 3 -> finish rises the cycle after the third commit, not before.
REQ-033 hartid=1 with TRACK_HART=0, commit wfi -> finish stays 0; the same commit with hartid=0 -> finish=1.
REQ-034 After finish=1 and mstatus!=0, pulse reset low between clock edges -> finish=0 and mstatus=0 before the next edge.

Source files
------------

// File: rtl/rtlfuzz_dromajo.sv
// rtlfuzz_dromajo: commit-stream monitor that flags test end and tracks mstatus reads
module rtlfuzz_dromajo #(
  parameter int          PC_W        = 40,
  parameter int          HART_W      = 1,
  parameter int          TRACK_HART  = 0,
  parameter logic [63:0] MAX_COMMITS = 64'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [HART_W-1:0] hartid,
  input  logic [PC_W-1:0]   pc,
  input  logic [31:0]       inst,
  input  logic [63:0]       wdata,
  output logic [63:0]       mstatus,
  output logic              finish
);
  logic [63:0]     cnt, cnt_nxt;
  logic [PC_W-1:0] last_pc;
  logic            commit, csr_rd, fin_hit;
  always_comb begin
    commit  = valid && hartid == HART_W'(TRACK_HART);
    cnt_nxt = &cnt ? cnt : cnt + 64'd1;
    // any CSR read form (reg or imm) of mstatus that writes a real register
    csr_rd  = inst[6:0] == 7'h73 && inst[14:12] != 3'd0 && inst[14:12] != 3'd4 &&
              inst[31:20] == 12'h300 && inst[11:7] != 5'd0;
    fin_hit = inst == 32'h0000006F || inst == 32'h10500073 ||
              (MAX_COMMITS != 64'd0 && cnt_nxt == MAX_COMMITS);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt     <= '0;
      last_pc <= '0;
      mstatus <= '0;
      finish  <= 1'b0;
    end else if (commit) begin
      cnt     <= cnt_nxt;
      last_pc <= pc;
      if (csr_rd) mstatus <= wdata;
      if (fin_hit) finish <= 1'b1;
    end
endmodule

// File: tb/tb_rtlfuzz_dromajo.sv
// tb_rtlfuzz_dromajo: vector table, directed corner sequences and randomized model check
module tb_rtlfuzz_dromajo;
  localparam logic [31:0] NOP = 32'h00000013, JAL = 32'h0000006F, WFI = 32'h10500073;
  localparam logic [31:0] CSRR_T0 = 32'h300022F3, CSRR_X0 = 32'h30002073;
  typedef struct {
    logic        v;
    logic        h;
    logic [31:0] i;
    logic [63:0] w;
    logic        ef;
    logic [63:0] ems;
  } vec_t;
  logic        clock = 1'b0, reset = 1'b0, valid = 1'b0;
  logic [0:0]  hartid = '0;
  logic [39:0] pc = '0;
  logic [31:0] inst = '0;
  logic [63:0] wdata = '0;
  logic [63:0] ms0, ms3;
  logic        fin0, fin3;
  int          n_chk = 0, n_fail = 0;
  logic [63:0] m_cnt, m_ms;
  logic        m_fin0, m_fin3;
  vec_t        tbl[$];
  rtlfuzz_dromajo dut0 (.clock(clock), .reset(reset), .valid(valid), .hartid(hartid), .pc(pc),
                        .inst(inst), .wdata(wdata), .mstatus(ms0), .finish(fin0));
  rtlfuzz_dromajo #(.MAX_COMMITS(64'd3)) dut3 (.clock(clock), .reset(reset), .valid(valid),
                        .hartid(hartid), .pc(pc), .inst(inst), .wdata(wdata), .mstatus(ms3), .finish(fin3));
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic logic is_mread(input logic [31:0] i);
    return i[6:0] == 7'h73 && (i[14:12] inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7}) &&
           i[31:20] == 12'h300 && i[11:7] != 5'd0;
  endfunction
  task automatic model_reset();
    m_cnt = 0; m_ms = 0; m_fin0 = 0; m_fin3 = 0;
  endtask
  // drive one cycle's inputs, let the edge happen, advance the model, land 1 time unit after the edge
  task automatic do_cycle(input logic v, input logic h, input logic [39:0] p, input logic [31:0] i,
                          input logic [63:0] w);
    valid = v; hartid = h; pc = p; inst = i; wdata = w;
    @(posedge clock);
    if (reset && v && h == 1'b0) begin
      if (m_cnt != '1) m_cnt = m_cnt + 1;
      if (i == JAL || i == WFI) begin m_fin0 = 1; m_fin3 = 1; end
      if (m_cnt == 3) m_fin3 = 1;
      if (is_mread(i)) m_ms = w;
    end
    #1;
  endtask
  task automatic pulse_reset(input string nm);
    reset = 1'b0;
    model_reset();
    #2;
    chk({nm, "_async_fin"}, 64'(fin0), 0);
    chk({nm, "_async_ms"}, ms0, 0);
    chk({nm, "_async_fin3"}, 64'(fin3), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask
  function automatic vec_t mk(input logic v, input logic h, input logic [31:0] i, input logic [63:0] w,
                              input logic ef, input logic [63:0] ems);
    vec_t r;
    r.v = v; r.h = h; r.i = i; r.w = w; r.ef = ef; r.ems = ems;
    return r;
  endfunction
  function automatic logic [31:0] rnd_inst();
    int sel = $urandom_range(0, 19);
    logic [11:0] csr = $urandom_range(0, 1) ? 12'h300 : 12'h301;
    if (sel == 0) return JAL;
    if (sel == 1) return WFI;
    if (sel < 8) return {csr, 5'($urandom), 3'($urandom), 5'($urandom_range(0, 3)), 7'h73};
    return $urandom;
  endfunction
  initial begin
    model_reset();
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1, 0, NOP, 64'h0, 0, 64'h0));
    tbl.push_back(mk(1, 0, CSRR_T0, 64'h0000000A00001800, 0, 64'h0000000A00001800));
    tbl.push_back(mk(1, 0, CSRR_X0, 64'hDEAD, 0, 64'h0000000A00001800));
    tbl.push_back(mk(1, 0, 32'h301022F3, 64'hBEEF, 0, 64'h0000000A00001800));
    tbl.push_back(mk(1, 1, CSRR_T0, 64'h5555, 0, 64'h0000000A00001800));
    tbl.push_back(mk(1, 1, WFI, 64'h0, 0, 64'h0000000A00001800));
    tbl.push_back(mk(0, 0, WFI, 64'h0, 0, 64'h0000000A00001800));
    tbl.push_back(mk(1, 0, 32'h300292F3, 64'h1234, 0, 64'h1234));
    tbl.push_back(mk(1, 0, 32'h3002C2F3, 64'h9999, 0, 64'h1234));
    tbl.push_back(mk(1, 0, 32'h000022F3, 64'h7777, 0, 64'h1234));
    tbl.push_back(mk(1, 0, 32'h300022B3, 64'h8888, 0, 64'h1234));
    tbl.push_back(mk(1, 0, WFI, 64'h0, 1, 64'h1234));
    tbl.push_back(mk(1, 0, CSRR_T0, 64'hCAFE, 1, 64'hCAFE));
    repeat (2) @(posedge clock);
    #1;
    chk("reset_fin", 64'(fin0), 0);
    chk("reset_ms", ms0, 0);
    reset = 1'b1;
    foreach (tbl[k]) begin
      do_cycle(tbl[k].v, tbl[k].h, 40'h80000000 + 40'(4 * k), tbl[k].i, tbl[k].w);
      chk($sformatf("vec%0d_fin", k), 64'(fin0), 64'(tbl[k].ef));
      chk($sformatf("vec%0d_ms", k), ms0, tbl[k].ems);
    end
    pulse_reset("midrun");
    do_cycle(1, 0, 40'h80000100, JAL, 64'h0);
    chk("jal_fin", 64'(fin0), 1);
    for (int k = 0; k < 10; k++) begin
      do_cycle(1'($urandom), 1'($urandom), 40'($urandom), $urandom, {$urandom, $urandom});
      chk($sformatf("jal_sticky%0d", k), 64'(fin0), 1);
    end
    pulse_reset("max");
    do_cycle(1, 0, 40'h0, NOP, 64'h0);
    chk("max_c1", 64'(fin3), 0);
    do_cycle(1, 0, 40'h4, NOP, 64'h0);
    chk("max_c2", 64'(fin3), 0);
    do_cycle(0, 0, 40'h8, NOP, 64'h0);
    chk("max_c3_idle", 64'(fin3), 0);
    do_cycle(1, 0, 40'h8, NOP, 64'h0);
    chk("max_c4", 64'(fin3), 1);
    chk("max_nolimit", 64'(fin0), 0);
    pulse_reset("rnd_start");
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset("rnd");
      do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 40'($urandom),
               rnd_inst(), {$urandom, $urandom});
      chk("rnd_fin", 64'(fin0), 64'(m_fin0));
      chk("rnd_fin3", 64'(fin3), 64'(m_fin3));
      chk("rnd_ms", ms0, m_ms);
      chk("rnd_ms3", ms3, m_ms);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
